mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles per owner while others wait; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 4, request from requester n on req[n].
REQ-005 SHALL have ports i0, i1, i2, i3, input, 1 each, the data bit from requesters 0..3.
REQ-006 SHALL have port gnt, output, 4, one-hot registered grant; 0 when no owner.
REQ-007 SHALL have ports s1 and s0, output, 1 each, the registered 2-bit select {s1,s0} equal to the owner index.
REQ-008 SHALL have port busy, output, 1, registered; 1 while an owner exists.
REQ-009 SHALL have port out, output, 1, the shared channel bit.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL keep a 2-bit round-robin pointer ptr; search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 SHALL, in IDLE with req!=0, grant the first requester in search order at the next edge: GRANT, gnt one-hot, {s1,s0}=index, busy=1, hold count=1.
REQ-013 SHALL have a grant latency of exactly one cycle from req sampled high in IDLE to gnt high.
REQ-014 SHALL, in GRANT with req[owner]=1, count<MAX_HOLD: keep the owner and increment the count.
REQ-015 SHALL, in GRANT with req[owner]=1, count==MAX_HOLD and another req bit set: re-grant to the first other requester searching from owner+1, count=1, with no idle cycle.
REQ-016 SHALL, in GRANT with req[owner]=1, count==MAX_HOLD and no other request: keep the owner and reload the count to 1.
REQ-017 SHALL, in GRANT with req[owner]=0 and another req bit set: grant the next requester from owner+1 at that edge, with no bubble.
REQ-018 SHALL, in GRANT with req=0: go to IDLE with gnt=0 and busy=0.
REQ-019 SHALL set ptr to (grantee index + 1) mod 4 on every new grant; a keep or reload leaves ptr unchanged.
REQ-020 SHALL hold {s1,s0} at the last owner index while IDLE.
REQ-021 SHALL drive out combinationally as busy AND the data selected by {s1,s0}: 00->i0, 01->i1, 10->i2, 11->i3; out=0 when busy=0.
REQ-022 SHALL always have gnt one-hot or zero, with busy == |gnt and gnt[{s1,s0}]==1 whenever busy=1.
REQ-023 SHALL treat simultaneous requests only through search order; no fixed priority beyond ptr.

Reset
REQ-024 SHALL, with reset=1 at an edge, set state=IDLE, gnt=0000, {s1,s0}=00, busy=0, ptr=0, count=0, regardless of req.
REQ-025 SHALL make reset win over all transitions, including mid-grant; the first grant after reset follows REQ-012 with ptr=0.
REQ-026 SHALL hold out=0 throughout reset and the following cycle.

Verification
REQ-027 SHALL cover: reset, then req=1010 for one cycle -> next cycle gnt=0010, {s1,s0}=01, busy=1; ptr becomes 2.
REQ-028 SHALL cover: MAX_HOLD=4, req=1111 held from IDLE after reset -> owners 0,1,2,3,0 each for exactly 4 cycles, no gnt=0 cycle between them.
REQ-029 SHALL cover: owner 2, req drops to 0001 -> next edge gnt=0001, {s1,s0}=00, count=1.
REQ-030 SHALL cover: req=0100 held alone for 10 cycles -> gnt=0100 every cycle, count cycles 1..4, ptr stays 3.
REQ-031 SHALL cover: owner 1 with i1 toggling 0,1,0 and i0=i2=i3=1 -> out follows i1 exactly; after req=0 -> out=0, {s1,s0} stays 01.
REQ-032 SHALL cover: reset asserted during GRANT with req=1111 -> next edge gnt=0000, busy=0; reset released -> gnt=0001 one cycle later.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Four-requester round-robin arbiter with a shared 1-bit data channel.
//   One owner at a time holds the channel for at most MAX_HOLD consecutive
//   cycles while others wait. An uncontested owner keeps the channel
//   indefinitely, with its hold count reloading to 1.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   reset      : synchronous active-high reset
//   req[3:0]   : request from requester n on req[n]
//   i0..i3     : data bit from requesters 0..3
//   gnt[3:0]   : registered one-hot grant, 0 when there is no owner
//   s1, s0     : registered owner index {s1,s0}; holds last owner in IDLE
//   busy       : registered, 1 while an owner exists
//   out        : shared channel bit = busy & data of selected requester
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic       out
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic [3:0] gnt_q,   gnt_d;
    logic       busy_q,  busy_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;

    logic [2:0] full_pick_s;   // {found, index} searching all four from ptr
    logic [2:0] other_pick_s;  // {found, index} searching the three non-owners
    logic       do_grant_s;
    logic [1:0] grant_idx_s;
    logic       data_s;

    // First set bit of r among span positions starting at start (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] start,
                                           input logic [2:0] span);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = start + 2'(k);
            if (!found && (3'(k) < span) && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign full_pick_s  = rr_pick(req, ptr_q, 3'd4);
    assign other_pick_s = rr_pick(req, sel_q + 2'd1, 3'd3);

    // Next-state decision: keep, reload, hand over, or release the channel.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        do_grant_s  = 1'b0;
        grant_idx_s = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (full_pick_s[2]) begin
                    do_grant_s  = 1'b1;
                    grant_idx_s = full_pick_s[1:0];
                end else begin
                    do_grant_s  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (req == 4'b0000) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (req[sel_q]) begin
                    if (cnt_q < MAX_HOLD_C) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (other_pick_s[2]) begin
                        do_grant_s  = 1'b1;
                        grant_idx_s = other_pick_s[1:0];
                    end else begin
                        // Nobody else is waiting: stay, restart the hold window.
                        cnt_d = 4'd1;
                    end
                end else if (other_pick_s[2]) begin
                    // Owner dropped but someone else waits: hand over, no bubble.
                    do_grant_s  = 1'b1;
                    grant_idx_s = other_pick_s[1:0];
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase

        if (do_grant_s) begin
            state_d = ST_GRANT;
            sel_d   = grant_idx_s;
            gnt_d   = 4'b0001 << grant_idx_s;
            busy_d  = 1'b1;
            cnt_d   = 4'd1;
            ptr_d   = grant_idx_s + 2'd1;
        end else begin
            state_d = state_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data select by the registered owner index.
    always_comb begin
        case (sel_q)
            2'd0:    data_s = i0;
            2'd1:    data_s = i1;
            2'd2:    data_s = i2;
            2'd3:    data_s = i3;
            default: data_s = 1'b0;
        endcase
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = busy_q;
    // Gating with reset keeps the channel quiet for the whole reset cycle,
    // not just from the reset edge onward.
    assign out  = busy_q & ~reset & data_s;

endmodule
